morra_cinese_param: RTL and testbench

Parametrised rock-paper-scissors ("morra cinese") referee, successor to the fixed-rule game FSM. One manche is judged per clock. The block enforces the move-repetition rule, keeps both players' score difference and the manche count, and declares the match result. Minimum manche count, maximum-length base and winning lead are parameters instead of hard-coded state encodings. It sits between the two player move inputs and the display/scoring logic.

---
 rtl/morra_cinese_param.sv | 139 +++++++++++++
 tb/tb_morra_cinese_param.sv | 139 +++++++++++++
 2 files changed

// File: rtl/morra_cinese_param.sv
`default_nettype none
// ============================================================================
// Module   : morra_cinese_param
// Brief    : Parametrised rock-paper-scissors referee, one manche per clock.
// Revision : 1.0 - initial release
// ============================================================================
module morra_cinese_param #(
    parameter int CNT_W      = 5,
    parameter int MIN_MANCHE = 4,
    parameter int MAX_BASE   = 4,
    parameter int LEAD_WIN   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             INIZIO,
    input  logic [1:0]       PRIMO,
    input  logic [1:0]       SECONDO,
    output logic [1:0]       MANCHE,
    output logic [1:0]       PARTITA,
    output logic             IN_CORSO,
    output logic [CNT_W-1:0] NUM_MANCHE,
    output logic [CNT_W:0]   VANTAGGIO
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GIOCO = 1'b1;

    localparam logic [CNT_W-1:0] C_MIN_MANCHE = CNT_W'(MIN_MANCHE);
    localparam logic [CNT_W-1:0] C_MAX_BASE   = CNT_W'(MAX_BASE);
    localparam logic [CNT_W:0]   C_LEAD_WIN   = (CNT_W+1)'(LEAD_WIN);
    localparam logic [CNT_W:0]   C_ONE        = (CNT_W+1)'(1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_max;
    logic [1:0]       r_prev_win;
    logic [1:0]       r_prev_move;

    logic             w_p1_beats;
    logic             w_repeat;
    logic [1:0]       w_res;
    logic [CNT_W-1:0] w_num_next;
    logic [CNT_W:0]   w_vant_next;
    logic [CNT_W:0]   w_vant_abs;
    logic [1:0]       w_sign_res;
    logic [1:0]       w_end_res;

    always_comb begin
        w_p1_beats = (PRIMO == 2'b10 && SECONDO == 2'b01) ||
                     (PRIMO == 2'b01 && SECONDO == 2'b11) ||
                     (PRIMO == 2'b11 && SECONDO == 2'b10);
        // The last winner may not replay the move it just won with.
        w_repeat   = (r_prev_win == 2'b01 && PRIMO   == r_prev_move) ||
                     (r_prev_win == 2'b10 && SECONDO == r_prev_move);

        w_res = 2'b00;
        if (PRIMO != 2'b00 && SECONDO != 2'b00 && !w_repeat) begin
            if (PRIMO == SECONDO) begin
                w_res = 2'b11;
            end else if (w_p1_beats) begin
                w_res = 2'b01;
            end else begin
                w_res = 2'b10;
            end
        end

        w_num_next  = NUM_MANCHE + 1'b1;
        w_vant_next = VANTAGGIO;
        if (w_res == 2'b01) begin
            w_vant_next = VANTAGGIO + C_ONE;
        end else if (w_res == 2'b10) begin
            w_vant_next = VANTAGGIO - C_ONE;
        end

        w_vant_abs = w_vant_next[CNT_W] ? (~w_vant_next + C_ONE) : w_vant_next;

        if (w_vant_next == '0) begin
            w_sign_res = 2'b11;
        end else if (w_vant_next[CNT_W]) begin
            w_sign_res = 2'b10;
        end else begin
            w_sign_res = 2'b01;
        end

        // End check evaluated on post-update values of a counted manche only.
        w_end_res = 2'b00;
        if (w_res != 2'b00) begin
            if (w_num_next >= C_MIN_MANCHE && w_vant_abs >= C_LEAD_WIN) begin
                w_end_res = w_sign_res;
            end else if (w_num_next == r_max) begin
                w_end_res = w_sign_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_max       <= '0;
            r_prev_win  <= 2'b00;
            r_prev_move <= 2'b00;
            MANCHE      <= 2'b00;
            PARTITA     <= 2'b00;
            NUM_MANCHE  <= '0;
            VANTAGGIO   <= '0;
        end else if (INIZIO) begin
            r_state     <= GIOCO;
            r_max       <= C_MAX_BASE + {{(CNT_W-4){1'b0}}, PRIMO, SECONDO};
            r_prev_win  <= 2'b00;
            r_prev_move <= 2'b00;
            MANCHE      <= 2'b00;
            PARTITA     <= 2'b00;
            NUM_MANCHE  <= '0;
            VANTAGGIO   <= '0;
        end else if (r_state == GIOCO) begin
            MANCHE  <= w_res;
            PARTITA <= w_end_res;
            if (w_res != 2'b00) begin
                NUM_MANCHE <= w_num_next;
                VANTAGGIO  <= w_vant_next;
                if (w_res == 2'b11) begin
                    r_prev_win <= 2'b00;
                end else begin
                    r_prev_win  <= w_res;
                    r_prev_move <= (w_res == 2'b01) ? PRIMO : SECONDO;
                end
            end
            if (w_end_res != 2'b00) begin
                r_state <= IDLE;
            end
        end else begin
            MANCHE  <= 2'b00;
            PARTITA <= 2'b00;
        end
    end

    assign IN_CORSO = (r_state == GIOCO);

endmodule
`default_nettype wire

// File: tb/tb_morra_cinese_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_morra_cinese_param
// Brief    : Directed vector bench for the morra cinese referee.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morra_cinese_param;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             INIZIO;
    logic [1:0]       PRIMO;
    logic [1:0]       SECONDO;
    logic [1:0]       MANCHE;
    logic [1:0]       PARTITA;
    logic             IN_CORSO;
    logic [CNT_W-1:0] NUM_MANCHE;
    logic [CNT_W:0]   VANTAGGIO;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rn;
        logic       ini;
        logic [1:0] p1;
        logic [1:0] p2;
        logic [1:0] man;
        logic [1:0] par;
        logic       inc;
        int         num;
        int         vant;
    } vec_t;

    vec_t vecs[$];

    morra_cinese_param #(
        .CNT_W(CNT_W), .MIN_MANCHE(4), .MAX_BASE(4), .LEAD_WIN(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .INIZIO(INIZIO), .PRIMO(PRIMO), .SECONDO(SECONDO),
        .MANCHE(MANCHE), .PARTITA(PARTITA), .IN_CORSO(IN_CORSO),
        .NUM_MANCHE(NUM_MANCHE), .VANTAGGIO(VANTAGGIO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        logic [CNT_W:0] ev;
        @(negedge clk);
        rst_n   = v.rn;
        INIZIO  = v.ini;
        PRIMO   = v.p1;
        SECONDO = v.p2;
        @(posedge clk);
        #1;
        ev = (CNT_W+1)'(v.vant);
        chk("manche",    idx, int'(MANCHE),     int'(v.man));
        chk("partita",   idx, int'(PARTITA),    int'(v.par));
        chk("in_corso",  idx, int'(IN_CORSO),   int'(v.inc));
        chk("num",       idx, int'(NUM_MANCHE), v.num);
        chk("vantaggio", idx, int'(VANTAGGIO),  int'(ev));
    endtask

    initial begin
        rst_n = 1'b0; INIZIO = 1'b0; PRIMO = 2'b00; SECONDO = 2'b00;

        // rn ini p1 p2 | manche partita in_corso num vant
        vecs.push_back('{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0});
        // P1 sweep, MAX=4
        vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1'b1, 1, 1});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 2'b11, 2'b01, 2'b00, 1'b1, 2, 2});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 2'b10, 2'b01, 2'b00, 1'b1, 3, 3});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b01, 2'b01, 2'b01, 1'b0, 4, 4});
        // idle ignores moves, keeps final counters
        vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 4, 4});
        // repetition rule
        vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1'b1, 1, 1});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b1, 1, 1});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1, 2, 1});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1'b1, 3, 2});
        // zero moves mid-match
        vecs.push_back('{1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 1'b1, 3, 2});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3, 2});
        // reset mid-match beats INIZIO
        vecs.push_back('{1'b0, 1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 0, 0});
        // max-length draw, MAX=4
        vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1'b1, 1, 1});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 1'b1, 2, 0});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1'b1, 3, 1});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b11, 1'b0, 4, 0});
        // restart with valid moves: config only, then P2 lead ends match (MAX=13)
        vecs.push_back('{1'b1, 1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 1'b1, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 1'b1, 1, -1});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 2'b01, 2'b10, 2'b00, 1'b1, 2, -2});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b11, 2'b10, 2'b00, 1'b1, 3, -3});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b10, 1'b0, 4, -4});
        // MAX=5 match aborted by INIZIO (11,11): no pulse, MAX becomes 19
        vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1'b1, 1, 1});
        vecs.push_back('{1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // 19 alternating-winner manches: P1 odd, P2 even, lead never reaches 2
        for (int m = 1; m <= 19; m++) begin
            vec_t v;
            v.rn   = 1'b1;
            v.ini  = 1'b0;
            v.p1   = (m % 2 == 1) ? 2'b10 : 2'b01;
            v.p2   = (m % 2 == 1) ? 2'b01 : 2'b10;
            v.man  = (m % 2 == 1) ? 2'b01 : 2'b10;
            v.par  = (m == 19) ? 2'b01 : 2'b00;
            v.inc  = (m == 19) ? 1'b0 : 1'b1;
            v.num  = m;
            v.vant = (m % 2 == 1) ? 1 : 0;
            step(v, 100 + m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
